// File: rtl/lsu_mem_ctl.sv
// rtl/lsu_mem_ctl.sv - multi-cycle load/store unit with valid/ready request, memory and result handshakes
module lsu_mem_ctl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int OFF_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
    input  logic                      i_sys_clk,
    input  logic                      i_sys_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_wr,
    input  logic [1:0]                i_req_size,
    input  logic                      i_req_sign,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    input  logic [DATA_WIDTH-1:0]     i_req_wdata,
    output logic                      o_mem_req_valid,
    input  logic                      i_mem_req_ready,
    output logic                      o_mem_req_wr,
    output logic [ADDR_WIDTH-1:0]     o_mem_req_addr,
    output logic [DATA_WIDTH-1:0]     o_mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]   o_mem_req_mask,
    input  logic                      i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     i_mem_rsp_data,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [DATA_WIDTH-1:0]     o_rsp_data,
    output logic                      o_rsp_err
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_wr;
    logic                    r_sign;
    logic                    r_err;
    logic [1:0]              r_size;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_req_fire;
    logic                    w_misalign;
    logic                    w_oversize;
    logic                    w_illegal;
    logic [OFF_WIDTH-1:0]    w_off;
    logic [7:0]              w_base;
    logic [NB-1:0]           w_lane;
    logic [DATA_WIDTH-1:0]   w_sh;
    logic [DATA_WIDTH-1:0]   w_ld;
    logic                    w_msb;
    int                      w_nbits;

    assign w_req_fire = i_req_valid & (r_state == S_IDLE);
    assign w_oversize = int'(i_req_size) > OFF_WIDTH;
    assign w_illegal  = w_misalign | w_oversize;
    assign w_off      = r_addr[OFF_WIDTH-1:0];

    // Alignment check on the incoming address: low log2(size) bits must be zero
    always_comb begin
        w_misalign = 1'b0;
        case (i_req_size)
            2'd1:    w_misalign = i_req_addr[0];
            2'd2:    w_misalign = |i_req_addr[1:0];
            2'd3:    w_misalign = |i_req_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    // Byte strobes: one bit per accessed byte, moved to the address offset
    always_comb begin
        w_base = 8'h00;
        case (r_size)
            2'd0:    w_base = 8'h01;
            2'd1:    w_base = 8'h03;
            2'd2:    w_base = 8'h0F;
            default: w_base = 8'hFF;
        endcase
        w_lane = NB'({8'h00, w_base} << w_off);
    end

    // Load alignment: shift the addressed bytes down, then sign- or zero-extend
    always_comb begin
        w_ld    = '0;
        w_sh    = i_mem_rsp_data >> {w_off, 3'b000};
        w_nbits = 8 << r_size;
        case (r_size)
            2'd0:    w_msb = w_sh[7];
            2'd1:    w_msb = w_sh[15];
            2'd2:    w_msb = w_sh[31];
            default: w_msb = w_sh[DATA_WIDTH-1];
        endcase
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_ld[i] = (i < w_nbits) ? w_sh[i] : (r_sign & w_msb);
        end
    end

    // State register
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt     = r_state;
        o_req_ready     = 1'b0;
        o_mem_req_valid = 1'b0;
        o_rsp_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    w_state_nxt = w_illegal ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rsp_valid) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture and load-result capture; a store ack always yields zero data
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_wr    <= 1'b0;
            r_sign  <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_req_fire) begin
                r_wr    <= i_req_wr;
                r_sign  <= i_req_sign;
                r_size  <= i_req_size;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_err   <= w_illegal;
                r_rdata <= '0;
            end
            if (r_state == S_WAIT && i_mem_rsp_valid) begin
                r_rdata <= r_wr ? '0 : w_ld;
            end
        end
    end

    // Payloads come only from registers and read as zero while their valid is low
    assign o_mem_req_wr    = o_mem_req_valid & r_wr;
    assign o_mem_req_addr  = o_mem_req_valid ? {r_addr[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}} : '0;
    assign o_mem_req_mask  = o_mem_req_wr ? w_lane : '0;
    assign o_mem_req_wdata = o_mem_req_valid ? (r_wdata << {w_off, 3'b000}) : '0;
    assign o_rsp_data      = o_rsp_valid ? r_rdata : '0;
    assign o_rsp_err       = o_rsp_valid & r_err;

endmodule

// File: tb/tb_lsu_mem_ctl.sv
// tb/tb_lsu_mem_ctl.sv - directed bench for lsu_mem_ctl with 64- and 32-bit instances
module tb_lsu_mem_ctl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel32 = 1'b0;
    logic        req_valid = 1'b0, req_wr = 1'b0, req_sign = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0, mem_rsp_data = '0;
    logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0, rsp_ready = 1'b0;

    logic        a_req_ready, a_mem_valid, a_mem_wr, a_rsp_valid, a_rsp_err;
    logic [31:0] a_mem_addr;
    logic [63:0] a_mem_wdata, a_rsp_data;
    logic [7:0]  a_mem_mask;
    logic        b_req_ready, b_mem_valid, b_mem_wr, b_rsp_valid, b_rsp_err;
    logic [31:0] b_mem_addr, b_mem_wdata, b_rsp_data;
    logic [3:0]  b_mem_mask;

    lsu_mem_ctl #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u64 (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_req_valid(req_valid & ~sel32), .o_req_ready(a_req_ready),
        .i_req_wr(req_wr), .i_req_size(req_size), .i_req_sign(req_sign),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_mem_req_valid(a_mem_valid), .i_mem_req_ready(mem_req_ready & ~sel32),
        .o_mem_req_wr(a_mem_wr), .o_mem_req_addr(a_mem_addr),
        .o_mem_req_wdata(a_mem_wdata), .o_mem_req_mask(a_mem_mask),
        .i_mem_rsp_valid(mem_rsp_valid & ~sel32), .i_mem_rsp_data(mem_rsp_data),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready & ~sel32),
        .o_rsp_data(a_rsp_data), .o_rsp_err(a_rsp_err)
    );

    lsu_mem_ctl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u32 (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_req_valid(req_valid & sel32), .o_req_ready(b_req_ready),
        .i_req_wr(req_wr), .i_req_size(req_size), .i_req_sign(req_sign),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata[31:0]),
        .o_mem_req_valid(b_mem_valid), .i_mem_req_ready(mem_req_ready & sel32),
        .o_mem_req_wr(b_mem_wr), .o_mem_req_addr(b_mem_addr),
        .o_mem_req_wdata(b_mem_wdata), .o_mem_req_mask(b_mem_mask),
        .i_mem_rsp_valid(mem_rsp_valid & sel32), .i_mem_rsp_data(mem_rsp_data[31:0]),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready & sel32),
        .o_rsp_data(b_rsp_data), .o_rsp_err(b_rsp_err)
    );

    logic        req_ready, mem_valid, mem_wr, rsp_valid, rsp_err;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, rsp_data;
    logic [7:0]  mem_mask;
    assign req_ready = sel32 ? b_req_ready : a_req_ready;
    assign mem_valid = sel32 ? b_mem_valid : a_mem_valid;
    assign mem_wr    = sel32 ? b_mem_wr    : a_mem_wr;
    assign mem_addr  = sel32 ? b_mem_addr  : a_mem_addr;
    assign mem_wdata = sel32 ? {32'd0, b_mem_wdata} : a_mem_wdata;
    assign mem_mask  = sel32 ? {4'd0, b_mem_mask}   : a_mem_mask;
    assign rsp_valid = sel32 ? b_rsp_valid : a_rsp_valid;
    assign rsp_data  = sel32 ? {32'd0, b_rsp_data}  : a_rsp_data;
    assign rsp_err   = sel32 ? b_rsp_err   : a_rsp_err;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: what the unit must present, computed from address/size arithmetic
    function automatic logic [63:0] f_dwm(input int dw);
        return (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic f_err(input int dw, input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        nbytes = 1 << size;
        return ((addr & 32'(nbytes - 1)) != 32'd0) || (nbytes > dw / 8);
    endfunction

    function automatic logic [63:0] f_mask(input int dw, input logic wr, input logic [1:0] size, input logic [31:0] addr);
        int nb, off;
        logic [63:0] m;
        nb  = dw / 8;
        off = int'(addr & 32'(nb - 1));
        if (!wr) return 64'd0;
        m = ((64'd1 << (1 << size)) - 64'd1) << off;
        return m & ((64'd1 << nb) - 64'd1);
    endfunction

    function automatic logic [63:0] f_wdata(input int dw, input logic [31:0] addr, input logic [63:0] wd);
        int off;
        off = int'(addr & 32'(dw / 8 - 1));
        return ((wd & f_dwm(dw)) << (8 * off)) & f_dwm(dw);
    endfunction

    function automatic logic [63:0] f_load(input int dw, input logic [1:0] size, input logic sign,
                                           input logic [31:0] addr, input logic [63:0] word);
        int off, nbits;
        logic [63:0] sh, keep, lowm;
        off   = int'(addr & 32'(dw / 8 - 1));
        sh    = (word & f_dwm(dw)) >> (8 * off);
        nbits = 8 << size;
        if (nbits >= 64) return sh;
        lowm = (64'd1 << nbits) - 64'd1;
        keep = sh & lowm;
        if (sign && keep[nbits-1]) keep = keep | ~lowm;
        return keep & f_dwm(dw);
    endfunction

    logic        m_active = 1'b0;
    logic        e_wr, e_err;
    logic [31:0] e_addr;
    logic [63:0] e_mask, e_wdata, e_data;

    logic        got_wr, got_err;
    logic [31:0] got_addr;
    logic [63:0] got_mask, got_wdata, got_data;

    // Every cycle: whatever the unit shows must match the model's expectation
    always @(negedge clk) begin
        if (!rst && m_active) begin
            if (mem_valid) begin
                chk("mem_addr", 64'(mem_addr), 64'(e_addr));
                chk("mem_wr", 64'(mem_wr), 64'(e_wr));
                chk("mem_mask", 64'(mem_mask), e_mask);
                chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (rsp_valid) begin
                chk("rsp_data", rsp_data, e_data);
                chk("rsp_err", 64'(rsp_err), 64'(e_err));
            end
        end else if (!rst) begin
            chk("idle_mem_valid", 64'(mem_valid), 64'd0);
            chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        end
    end

    task automatic set_model(input bit s32, input logic wr, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] word);
        int dw;
        dw      = s32 ? 32 : 64;
        e_err   = f_err(dw, size, addr);
        e_wr    = wr;
        e_addr  = addr & ~32'(dw / 8 - 1);
        e_mask  = f_mask(dw, wr, size, addr);
        e_wdata = f_wdata(dw, addr, wdata);
        e_data  = (e_err || wr) ? 64'd0 : f_load(dw, size, sign, addr, word);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, "_mem_wr"}, 64'(mem_wr), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_mem_mask"}, 64'(mem_mask), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, rsp_data, 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    endtask

    task automatic do_access(input bit s32, input logic wr, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] word,
                             input int req_stall, input int rsp_stall);
        int cyc, first_mem, first_rsp, nreq, rs, ps;
        bit done, pend;
        set_model(s32, wr, size, sign, addr, wdata, word);
        got_wr = 1'b0; got_err = 1'b0; got_addr = '0; got_mask = '0; got_wdata = '0; got_data = '0;
        @(posedge clk); #1;
        sel32 = s32; m_active = 1'b1;
        req_valid = 1'b1; req_wr = wr; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; rsp_ready = 1'b0; mem_rsp_data = word;
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0; done = 1'b0; pend = 1'b0; nreq = 0; rs = 0; ps = 0; first_mem = -1; first_rsp = -1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            chk("busy_not_ready", 64'(req_ready), 64'd0);
            if (mem_valid && first_mem < 0) first_mem = cyc;
            if (rsp_valid && first_rsp < 0) first_rsp = cyc;
            mem_rsp_valid = pend;
            pend = 1'b0;
            mem_req_ready = 1'b0;
            if (mem_valid) begin
                got_wr = mem_wr; got_addr = mem_addr; got_mask = 64'(mem_mask); got_wdata = mem_wdata;
                if (rs >= req_stall) begin
                    mem_req_ready = 1'b1; pend = 1'b1; nreq++;
                end else begin
                    rs++;
                end
            end
            rsp_ready = 1'b0;
            if (rsp_valid) begin
                got_data = rsp_data; got_err = rsp_err;
                if (ps >= rsp_stall) begin
                    rsp_ready = 1'b1; done = 1'b1;
                end else begin
                    ps++;
                end
            end
        end
        chk("txn_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("idle_after_rsp", 64'(req_ready), 64'd1);
        chk("rsp_dropped", 64'(rsp_valid), 64'd0);
        m_active = 1'b0;
        if (e_err) begin
            chk("err_latency", 64'(first_rsp), 64'd1);
            chk("err_no_mem_req", 64'(nreq), 64'd0);
        end else begin
            chk("mem_latency", 64'(first_mem), 64'd1);
            chk("rsp_latency", 64'(first_rsp), 64'(3 + req_stall));
            chk("mem_req_count", 64'(nreq), 64'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("rst64");
        sel32 = 1'b1; #1;
        check_idle("rst32");
        sel32 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // signed and unsigned byte loads from byte 3
        do_access(1'b0, 1'b0, 2'd0, 1'b1, 32'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        chk("t1_addr", 64'(got_addr), 64'h1000);
        chk("t1_data", got_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("t1_err", 64'(got_err), 64'd0);
        do_access(1'b0, 1'b0, 2'd0, 1'b0, 32'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        chk("t2_data", got_data, 64'h80);

        // halfword store at offset 6; ack data must not leak into the result
        do_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h2006, 64'hABCD, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0);
        chk("t3_mask", got_mask, 64'hC0);
        chk("t3_wdata", got_wdata, 64'hABCD_0000_0000_0000);
        chk("t3_wr", 64'(got_wr), 64'd1);
        chk("t3_addr", 64'(got_addr), 64'h2000);
        chk("t3_data", got_data, 64'd0);

        // misaligned word load
        do_access(1'b0, 1'b0, 2'd2, 1'b0, 32'h2002, 64'd0, 64'h1111_2222_3333_4444, 0, 0);
        chk("t4_err", 64'(got_err), 64'd1);
        chk("t4_data", got_data, 64'd0);

        // 32-bit instance: oversize, then full-word signed load
        do_access(1'b1, 1'b0, 2'd3, 1'b0, 32'h10, 64'd0, 64'h8000_0001, 0, 0);
        chk("t5_err", 64'(got_err), 64'd1);
        do_access(1'b1, 1'b0, 2'd2, 1'b1, 32'h10, 64'd0, 64'h8000_0001, 0, 0);
        chk("t6_data", got_data, 64'h8000_0001);
        chk("t6_addr", 64'(got_addr), 64'h10);
        do_access(1'b1, 1'b1, 2'd0, 1'b0, 32'h23, 64'h5A, 64'h0, 0, 0);
        chk("t7_mask", got_mask, 64'h8);
        chk("t7_wdata", got_wdata, 64'h5A00_0000);

        // backpressure on both the memory request and the result
        do_access(1'b0, 1'b0, 2'd0, 1'b0, 32'h3005, 64'd0, 64'h0000_AB00_0000_0000, 3, 2);
        chk("t8_data", got_data, 64'hAB);

        // doubleword load passes through; signed halfword; misaligned doubleword store
        do_access(1'b0, 1'b0, 2'd3, 1'b1, 32'h4008, 64'd0, 64'hF123_4567_89AB_CDEF, 0, 0);
        chk("t9_data", got_data, 64'hF123_4567_89AB_CDEF);
        do_access(1'b0, 1'b0, 2'd1, 1'b1, 32'h100A, 64'd0, 64'h0000_0000_8001_0000, 1, 1);
        chk("t10_data", got_data, 64'hFFFF_FFFF_FFFF_8001);
        do_access(1'b0, 1'b1, 2'd3, 1'b0, 32'h5004, 64'h1234, 64'd0, 0, 0);
        chk("t11_err", 64'(got_err), 64'd1);

        // reset while waiting for the memory response, then a stray response
        sel32 = 1'b0;
        set_model(1'b0, 1'b0, 2'd0, 1'b1, 32'h1003, 64'd0, 64'h0000_0000_8000_0000);
        @(posedge clk); #1;
        m_active = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd0; req_sign = 1'b1; req_addr = 32'h1003; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk("rw_mem_valid", 64'(mem_valid), 64'd1);
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        @(negedge clk);
        chk("rw_wait_busy", 64'(req_ready), 64'd0);
        chk("rw_wait_no_rsp", 64'(rsp_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_active = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0000_8000_0000;
        repeat (2) begin
            @(negedge clk);
            check_idle("rw_stray");
        end
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rw_no_result", 64'(rsp_valid), 64'd0);
        end

        // unit still works after the abandoned access
        do_access(1'b0, 1'b0, 2'd0, 1'b0, 32'h1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        chk("t12_data", got_data, 64'h80);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctl.md
Name: lsu_mem_ctl

Overview:
- Parametrised, multi-cycle load/store unit between the execute stage and a data-memory port.
- Replaces the single-cycle, always-valid LSU with real valid/ready handshakes on three interfaces: upstream request, memory request/response, and result.
- Generalised in data width. Stores use address-offset byte lanes. Loads align and sign- or zero-extend data for 1/2/4/8-byte accesses.
- Detects misaligned and oversize accesses and reports them as errors without touching memory.

Parameters:
- DATA_WIDTH, 64, memory/GPR data width; legal values 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- OFF_WIDTH, $clog2(DATA_WIDTH/8), byte-offset bits within one memory word (derived; do not override).

Ports:
- i_sys_clk  in  1  clock
- i_sys_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  upstream access request valid
- o_req_ready  out  1  unit can accept a request (high only in IDLE)
- i_req_wr  in  1  1 = store, 0 = load
- i_req_size  in  2  log2 of access bytes: 0=1B, 1=2B, 2=4B, 3=8B
- i_req_sign  in  1  load result is sign-extended (ignored for stores)
- i_req_addr  in  ADDR_WIDTH  byte address (EXU result)
- i_req_wdata  in  DATA_WIDTH  store data (rs2), right-justified
- o_mem_req_valid  out  1  memory request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_req_wr  out  1  memory write enable
- o_mem_req_addr  out  ADDR_WIDTH  word-aligned address (low OFF_WIDTH bits zero)
- o_mem_req_wdata  out  DATA_WIDTH  store data shifted to its byte lanes
- o_mem_req_mask  out  DATA_WIDTH/8  byte write strobes
- i_mem_rsp_valid  in  1  memory response valid (read data or write ack)
- i_mem_rsp_data  in  DATA_WIDTH  memory read word
- o_rsp_valid  out  1  result valid
- i_rsp_ready  in  1  consumer accepts result
- o_rsp_data  out  DATA_WIDTH  aligned, extended load data; 0 for stores and errors
- o_rsp_err  out  1  access was misaligned or oversize; no memory access was made

Behaviour:
- Reset: state IDLE. All outputs 0 except o_req_ready=1. All captured request registers are cleared.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: o_req_ready=1. A handshake (i_req_valid & o_req_ready) captures wr, size, sign, addr and wdata.
  - If the access is legal, go to REQ.
  - If it is illegal, go to RESP with err=1.
- Illegal access:
  - misaligned: addr mod (1<<size) != 0; or
  - oversize: (1<<size) > DATA_WIDTH/8.
- REQ: o_mem_req_valid=1. Payload is stable and driven from registers. On i_mem_req_ready, go to WAIT. The payload is held unchanged while ready is low.
- WAIT: on i_mem_rsp_valid, capture the processed load data (or 0 for a store), then go to RESP. Store responses are acks; their data is ignored.
- RESP: o_rsp_valid=1. o_rsp_data and o_rsp_err stay stable until i_rsp_ready, then go to IDLE.
- Only one access is outstanding at a time. A new request is accepted one cycle after the response handshake, never in the same cycle.
- Minimum latency, with the request accepted at cycle 0 and mem ready/response immediate:
  - o_mem_req_valid at cycle 1;
  - response seen at cycle 2;
  - o_rsp_valid at cycle 3.
- Error latency: o_rsp_valid at cycle 1.
- Offset and data mapping, with off = addr[OFF_WIDTH-1:0]:
  - o_mem_req_addr = addr with the low OFF_WIDTH bits cleared.
  - mask = ((1<<(1<<size))-1) << off, truncated to DATA_WIDTH/8 bits.
  - wdata lanes = i_req_wdata << (8*off).
  - For loads: o_mem_req_wr=0 and mask=0.
- Load data: sh = i_mem_rsp_data >> (8*off), keep the low 8<<size bits, then extend.
  - Sign-extend from the top kept bit if sign=1, else zero-extend.
  - size 3 with DATA_WIDTH 64 passes all 64 bits unchanged.
- A memory response arriving outside WAIT is ignored. A response arriving while in REQ is a protocol violation and does not need to be handled.
- Reset asserted in any state: next cycle is IDLE with reset outputs. Any in-flight memory request is abandoned, and a later stray response is ignored.

Test Plan:
- Reset, then load with DATA_WIDTH=64: addr=0x1003, size=0, sign=1, memory word 0x0000_0000_8000_0000 shifted so byte 3 = 0x80 -> o_mem_req_addr=0x1000, o_rsp_data=0xFFFF_FFFF_FFFF_FF80, err=0. With sign=0 the same load gives 0x80.
- Store with addr=0x2006, size=1, wdata=0xABCD -> o_mem_req_mask=0xC0, o_mem_req_wdata=0xABCD_0000_0000_0000, o_mem_req_wr=1; after the ack, o_rsp_data=0.
- Misaligned load with addr=0x2002, size=2 -> o_mem_req_valid never rises; o_rsp_valid at cycle 1 with err=1, data=0.
- Oversize access with DATA_WIDTH=32, size=3 -> err=1. Word load addr=0x10, size=2, sign=1, data 0x8000_0001 -> 0x8000_0001 (no further extension).
- Backpressure: hold i_mem_req_ready low for 3 cycles and i_rsp_ready low for 2 cycles -> request payload and response stay stable; o_req_ready=0 throughout; exactly one memory request is issued.
- Assert reset during WAIT, then drive i_mem_rsp_valid -> unit is in IDLE with o_req_ready=1, o_rsp_valid=0, and the stray response produces no result.
